// File: rtl/phy_tx_mutex_arbiter.sv
// phy_tx_mutex_arbiter
// Grants exclusive ownership of sets of PHY-TX FIFOs to a small group of
// requesters. A grant is all-or-nothing on the requested port mask, one grant
// is issued per cycle, and a round-robin head that is blocked reserves its
// ports so that narrower requests cannot starve it. A per-requester watchdog
// force-releases grants that are held too long.
module phy_tx_mutex_arbiter #(
    parameter int          NREQ     = 5,
    parameter int          NPORT    = 4,
    parameter logic [15:0] HOLD_MAX = 16'd2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ*NPORT-1:0] mutex_req,
    output logic [NREQ*NPORT-1:0] mutex_val,
    output logic [NPORT-1:0]      port_busy,
    output logic [NREQ-1:0]       timeout_pulse,
    output logic                  proto_err
);

    localparam int          IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    // Registered state
    logic [NREQ-1:0][NPORT-1:0] val_r;        // granted mask per requester
    logic [NPORT-1:0]           owner_vld_r;  // port is owned
    logic [NPORT-1:0][IW-1:0]   owner_id_r;   // which requester owns the port
    logic [NREQ-1:0][15:0]      hold_cnt_r;   // cycles the current grant has been held
    logic [NREQ-1:0]            lockout_r;    // timed out, waiting for request to drop
    logic [IW-1:0]              rr_ptr_r;     // round-robin scan start
    logic [NREQ-1:0]            timeout_r;
    logic                       proto_err_r;

    // Combinational decode
    logic [NREQ-1:0][NPORT-1:0] req_s;
    logic [NREQ-1:0]            release_s;
    logic [NREQ-1:0]            expire_s;
    logic [NREQ-1:0]            drop_s;
    logic [NREQ-1:0]            waiting_s;
    logic [NREQ-1:0]            illegal_s;
    logic [NPORT-1:0]           free_s;
    logic [NPORT-1:0]           reserved_s;
    logic [NPORT-1:0]           grant_mask_s;
    logic                       head_found_s;
    logic                       head_blocked_s;
    logic                       grant_s;
    logic [IW-1:0]              head_s;
    logic [IW-1:0]              winner_s;
    logic [IW-1:0]              scan_h_s;
    logic [IW-1:0]              scan_w_s;

    assign req_s         = mutex_req;
    assign mutex_val     = val_r;
    assign port_busy     = owner_vld_r;
    assign timeout_pulse = timeout_r;
    assign proto_err     = proto_err_r;
    assign drop_s        = release_s | expire_s;

    // Per-requester status: release, watchdog expiry, waiting and illegal mask change
    always_comb begin
        release_s = '0;
        expire_s  = '0;
        waiting_s = '0;
        illegal_s = '0;
        for (int r = 0; r < NREQ; r++) begin
            release_s[r] = (|val_r[r]) & ~(|req_s[r]);
            // Expiry is the edge on which the held count would reach HOLD_MAX
            expire_s[r]  = (|val_r[r]) & (|req_s[r]) & (HOLD_MAX != 16'd0)
                         & (hold_cnt_r[r] == (HOLD_MAX - 16'd1));
            waiting_s[r] = (|req_s[r]) & ~(|val_r[r]) & ~lockout_r[r];
            illegal_s[r] = (|val_r[r]) & (|req_s[r]) & (req_s[r] != val_r[r]);
        end
    end

    // Ports whose owner releases or times out this cycle
    always_comb begin
        free_s = '0;
        for (int p = 0; p < NPORT; p++) begin
            free_s[p] = owner_vld_r[p] & drop_s[owner_id_r[p]];
        end
    end

    // Find the round-robin head and the ports it reserves while blocked
    always_comb begin
        head_found_s = 1'b0;
        head_s       = '0;
        scan_h_s     = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_h_s = IW'((int'(rr_ptr_r) + i) % NREQ);
            if (waiting_s[scan_h_s] && !head_found_s) begin
                head_found_s = 1'b1;
                head_s       = scan_h_s;
            end else begin
                head_s       = head_s;
            end
        end
        head_blocked_s = head_found_s && ((req_s[head_s] & owner_vld_r) != '0);
        if (head_blocked_s) begin
            reserved_s = req_s[head_s];
        end else begin
            reserved_s = '0;
        end
    end

    // Pick the first waiting requester whose mask avoids owned and reserved ports
    always_comb begin
        grant_s  = 1'b0;
        winner_s = '0;
        scan_w_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_w_s = IW'((int'(rr_ptr_r) + i) % NREQ);
            if (!grant_s && waiting_s[scan_w_s]
                && ((req_s[scan_w_s] & (owner_vld_r | reserved_s)) == '0)) begin
                grant_s  = 1'b1;
                winner_s = scan_w_s;
            end else begin
                winner_s = winner_s;
            end
        end
        if (grant_s) begin
            grant_mask_s = req_s[winner_s];
        end else begin
            grant_mask_s = '0;
        end
    end

    // Granted masks: cleared on release or expiry, loaded on grant
    always_ff @(posedge clk) begin
        if (rst) begin
            val_r <= '0;
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                if (drop_s[r]) begin
                    val_r[r] <= '0;
                end else if (grant_s && (winner_s == IW'(r))) begin
                    val_r[r] <= req_s[r];
                end else begin
                    val_r[r] <= val_r[r];
                end
            end
        end
    end

    // Port owner table
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_vld_r <= '0;
            owner_id_r  <= '0;
        end else begin
            owner_vld_r <= (owner_vld_r & ~free_s) | grant_mask_s;
            for (int p = 0; p < NPORT; p++) begin
                if (grant_mask_s[p]) begin
                    owner_id_r[p] <= winner_s;
                end else begin
                    owner_id_r[p] <= owner_id_r[p];
                end
            end
        end
    end

    // Watchdog hold counters and post-timeout lockout
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r <= '0;
            lockout_r  <= '0;
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                if (grant_s && (winner_s == IW'(r))) begin
                    hold_cnt_r[r] <= 16'd0;
                end else if ((|val_r[r]) && (hold_cnt_r[r] != CNT_SAT)) begin
                    hold_cnt_r[r] <= hold_cnt_r[r] + 16'd1;
                end else begin
                    hold_cnt_r[r] <= hold_cnt_r[r];
                end
                if (expire_s[r]) begin
                    lockout_r[r] <= 1'b1;
                end else if (~(|req_s[r])) begin
                    lockout_r[r] <= 1'b0;
                end else begin
                    lockout_r[r] <= lockout_r[r];
                end
            end
        end
    end

    // Round-robin pointer only moves past the head once the head is served
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (grant_s && head_found_s && (winner_s == head_s)) begin
            rr_ptr_r <= (winner_s == IW'(NREQ - 1)) ? '0 : (winner_s + IW'(1));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Timeout pulse and sticky protocol error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_r   <= '0;
            proto_err_r <= 1'b0;
        end else begin
            timeout_r   <= expire_s;
            proto_err_r <= proto_err_r | (|illegal_s);
        end
    end

endmodule

// File: tb/tb_phy_tx_mutex_arbiter.sv
// Testbench for phy_tx_mutex_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// behavioural model built from port-owner lists and a waiting queue.
module tb_phy_tx_mutex_arbiter;

    localparam int NREQ  = 5;
    localparam int NPORT = 4;
    localparam int HM    = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ*NPORT-1:0] mutex_req;
    logic [NREQ*NPORT-1:0] mutex_val;
    logic [NPORT-1:0]      port_busy;
    logic [NREQ-1:0]       timeout_pulse;
    logic                  proto_err;

    int checks;
    int failures;

    // Behavioural model state
    int               owner_m [NPORT];   // -1 = free, else requester index
    logic [NPORT-1:0] grant_m [NREQ];
    int               held_m  [NREQ];
    bit               lock_m  [NREQ];
    int               rr_m;
    bit               perr_m;
    logic [NREQ-1:0]  tmo_m;

    phy_tx_mutex_arbiter #(
        .NREQ     (NREQ),
        .NPORT    (NPORT),
        .HOLD_MAX (16'd8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mutex_req     (mutex_req),
        .mutex_val     (mutex_val),
        .port_busy     (port_busy),
        .timeout_pulse (timeout_pulse),
        .proto_err     (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ*NPORT-1:0] rq5(input logic [3:0] a0, input logic [3:0] a1,
                                                  input logic [3:0] a2, input logic [3:0] a3,
                                                  input logic [3:0] a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [NPORT-1:0] mv(input int r);
        return mutex_val[r*NPORT +: NPORT];
    endfunction

    task automatic free_ports_of(input int r);
        for (int p = 0; p < NPORT; p++) begin
            if (owner_m[p] == r) owner_m[p] = -1;
        end
    endtask

    // Advance the model across one rising edge given the inputs seen at that edge
    task automatic model_step(input bit r_in, input logic [NREQ*NPORT-1:0] rq);
        logic [NPORT-1:0] m [NREQ];
        logic [NPORT-1:0] owned;
        logic [NPORT-1:0] resv;
        int order[$];
        int head;
        int win;
        for (int r = 0; r < NREQ; r++) m[r] = rq[r*NPORT +: NPORT];
        tmo_m = '0;
        if (r_in) begin
            for (int p = 0; p < NPORT; p++) owner_m[p] = -1;
            for (int r = 0; r < NREQ; r++) begin
                grant_m[r] = '0;
                held_m[r]  = 0;
                lock_m[r]  = 1'b0;
            end
            rr_m   = 0;
            perr_m = 1'b0;
            return;
        end
        owned = '0;
        for (int p = 0; p < NPORT; p++) owned[p] = (owner_m[p] >= 0);
        for (int k = 0; k < NREQ; k++) begin
            int r;
            r = (rr_m + k) % NREQ;
            if (m[r] != '0 && grant_m[r] == '0 && !lock_m[r]) order.push_back(r);
        end
        head = -1;
        win  = -1;
        resv = '0;
        if (order.size() > 0) begin
            head = order[0];
            if ((m[head] & owned) != '0) resv = m[head];
            foreach (order[i]) begin
                if (win < 0 && (m[order[i]] & (owned | resv)) == '0) win = order[i];
            end
        end
        for (int r = 0; r < NREQ; r++) begin
            if (grant_m[r] != '0) begin
                if (m[r] == '0) begin
                    free_ports_of(r);
                    grant_m[r] = '0;
                end else begin
                    if (m[r] != grant_m[r]) perr_m = 1'b1;
                    held_m[r]++;
                    if (HM != 0 && held_m[r] == HM) begin
                        free_ports_of(r);
                        grant_m[r] = '0;
                        tmo_m[r]   = 1'b1;
                        lock_m[r]  = 1'b1;
                    end
                end
            end else if (m[r] == '0) begin
                lock_m[r] = 1'b0;
            end
        end
        if (win >= 0) begin
            grant_m[win] = m[win];
            held_m[win]  = 0;
            for (int p = 0; p < NPORT; p++) begin
                if (m[win][p]) owner_m[p] = win;
            end
            if (win == head) rr_m = (win + 1) % NREQ;
        end
    endtask

    task automatic compare();
        logic [NREQ*NPORT-1:0] ev;
        logic [NPORT-1:0]      eb;
        for (int r = 0; r < NREQ; r++) ev[r*NPORT +: NPORT] = grant_m[r];
        for (int p = 0; p < NPORT; p++) eb[p] = (owner_m[p] >= 0);
        chk("model_mutex_val", 32'(mutex_val), 32'(ev));
        chk("model_port_busy", 32'(port_busy), 32'(eb));
        chk("model_timeout", 32'(timeout_pulse), 32'(tmo_m));
        chk("model_proto_err", 32'(proto_err), 32'(perr_m));
    endtask

    // One clock: drive at the falling edge, step the model, sample at the next falling edge
    task automatic tick(input logic [NREQ*NPORT-1:0] rq, input bit r_in);
        rst       = r_in;
        mutex_req = rq;
        model_step(r_in, rq);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [NREQ*NPORT-1:0] cur;
        logic [NPORT-1:0]      nm;
        logic [NPORT-1:0]      cm;
        int                    u;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        mutex_req = '0;

        // Reset state
        tick('0, 1'b1);
        chk("rst_val", 32'(mutex_val), 32'd0);
        chk("rst_busy", 32'(port_busy), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);

        // Single grant and release
        tick(rq5(4'h0, 4'h0, 4'h0, 4'h0, 4'h5), 1'b0);
        chk("single_val4", 32'(mv(4)), 32'h5);
        chk("single_busy", 32'(port_busy), 32'h5);
        for (int i = 0; i < 4; i++) tick(rq5(4'h0, 4'h0, 4'h0, 4'h0, 4'h5), 1'b0);
        tick('0, 1'b0);
        chk("single_rel_val4", 32'(mv(4)), 32'h0);
        chk("single_rel_busy", 32'(port_busy), 32'h0);

        // Contention on one port with a one-cycle handoff gap
        tick('0, 1'b1);
        tick(rq5(4'h1, 4'h1, 4'h0, 4'h0, 4'h0), 1'b0);
        chk("cont_val0", 32'(mv(0)), 32'h1);
        chk("cont_val1", 32'(mv(1)), 32'h0);
        tick(rq5(4'h1, 4'h1, 4'h0, 4'h0, 4'h0), 1'b0);
        tick(rq5(4'h0, 4'h1, 4'h0, 4'h0, 4'h0), 1'b0);
        chk("cont_gap_val0", 32'(mv(0)), 32'h0);
        chk("cont_gap_val1", 32'(mv(1)), 32'h0);
        tick(rq5(4'h0, 4'h1, 4'h0, 4'h0, 4'h0), 1'b0);
        chk("cont_hand_val1", 32'(mv(1)), 32'h1);

        // Blocked multi-port head reserves its ports against later narrow requests
        tick('0, 1'b1);
        tick(rq5(4'h0, 4'h2, 4'h0, 4'h0, 4'h0), 1'b0);
        chk("starve_val1", 32'(mv(1)), 32'h2);
        tick(rq5(4'h0, 4'h2, 4'h0, 4'h8, 4'h0), 1'b0);
        chk("starve_val3", 32'(mv(3)), 32'h8);
        tick(rq5(4'h0, 4'h2, 4'h0, 4'h8, 4'hF), 1'b0);
        chk("starve_head_wait", 32'(mv(4)), 32'h0);
        tick(rq5(4'h0, 4'h2, 4'h0, 4'h0, 4'hF), 1'b0);
        chk("starve_busy_a", 32'(port_busy), 32'h2);
        tick(rq5(4'h0, 4'h2, 4'h4, 4'h0, 4'hF), 1'b0);
        chk("starve_r2_held_a", 32'(mv(2)), 32'h0);
        tick(rq5(4'h0, 4'h2, 4'h4, 4'h0, 4'hF), 1'b0);
        chk("starve_r2_held_b", 32'(mv(2)), 32'h0);
        tick(rq5(4'h0, 4'h0, 4'h4, 4'h0, 4'hF), 1'b0);
        chk("starve_r2_held_c", 32'(mv(2)), 32'h0);
        chk("starve_busy_b", 32'(port_busy), 32'h0);
        tick(rq5(4'h0, 4'h0, 4'h4, 4'h0, 4'hF), 1'b0);
        chk("starve_head_val4", 32'(mv(4)), 32'hF);
        chk("starve_r2_after", 32'(mv(2)), 32'h0);
        tick(rq5(4'h0, 4'h0, 4'h4, 4'h0, 4'h0), 1'b0);
        tick(rq5(4'h0, 4'h0, 4'h4, 4'h0, 4'h0), 1'b0);
        chk("starve_r2_final", 32'(mv(2)), 32'h4);

        // Disjoint grants on consecutive cycles held together
        tick('0, 1'b1);
        tick(rq5(4'h1, 4'h0, 4'h0, 4'h8, 4'h0), 1'b0);
        chk("disj_val0", 32'(mv(0)), 32'h1);
        chk("disj_val3_first", 32'(mv(3)), 32'h0);
        tick(rq5(4'h1, 4'h0, 4'h0, 4'h8, 4'h0), 1'b0);
        chk("disj_val3", 32'(mv(3)), 32'h8);
        chk("disj_busy", 32'(port_busy), 32'h9);

        // Watchdog expiry, lockout, and re-grant after dropping through zero
        tick('0, 1'b1);
        tick(rq5(4'h0, 4'h0, 4'h3, 4'h0, 4'h0), 1'b0);
        for (int i = 1; i < HM; i++) begin
            tick(rq5(4'h0, 4'h0, 4'h3, 4'h0, 4'h0), 1'b0);
            chk("wd_held", 32'(mv(2)), 32'h3);
        end
        tick(rq5(4'h0, 4'h0, 4'h3, 4'h0, 4'h0), 1'b0);
        chk("wd_expire_val", 32'(mv(2)), 32'h0);
        chk("wd_expire_pulse", 32'(timeout_pulse), 32'h4);
        chk("wd_expire_busy", 32'(port_busy), 32'h0);
        tick(rq5(4'h0, 4'h0, 4'h3, 4'h0, 4'h0), 1'b0);
        chk("wd_locked_val", 32'(mv(2)), 32'h0);
        chk("wd_pulse_end", 32'(timeout_pulse), 32'h0);
        tick('0, 1'b0);
        chk("wd_drop_val", 32'(mv(2)), 32'h0);
        tick(rq5(4'h0, 4'h0, 4'h3, 4'h0, 4'h0), 1'b0);
        chk("wd_regrant", 32'(mv(2)), 32'h3);

        // Illegal mask change while holding, then reset mid-hold
        tick('0, 1'b1);
        tick(rq5(4'h1, 4'h0, 4'h0, 4'h0, 4'h0), 1'b0);
        tick(rq5(4'h3, 4'h0, 4'h0, 4'h0, 4'h0), 1'b0);
        chk("proto_keep", 32'(mv(0)), 32'h1);
        chk("proto_flag", 32'(proto_err), 32'h1);
        tick(rq5(4'h3, 4'h0, 4'h0, 4'h0, 4'h0), 1'b1);
        chk("midrst_val", 32'(mutex_val), 32'h0);
        chk("midrst_busy", 32'(port_busy), 32'h0);
        chk("midrst_perr", 32'(proto_err), 32'h0);
        tick(rq5(4'h3, 4'h0, 4'h0, 4'h0, 4'h0), 1'b0);
        chk("postrst_grant", 32'(mv(0)), 32'h3);

        // Randomized traffic
        tick('0, 1'b1);
        cur = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                cm = cur[r*NPORT +: NPORT];
                u  = $urandom_range(0, 99);
                if ($urandom_range(0, 1) == 0) nm = 4'(1 << $urandom_range(0, 3));
                else                           nm = 4'($urandom_range(1, 15));
                if (cm == '0) begin
                    if (u < 30) cm = nm;
                end else if (u < 10) begin
                    cm = '0;
                end else if (u < 11) begin
                    cm = nm;
                end
                cur[r*NPORT +: NPORT] = cm;
            end
            tick(cur, ($urandom_range(0, 399) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phy_tx_mutex_arbiter.md
PHY_TX_MUTEX_ARBITER -- requirements
Module: phy_tx_mutex_arbiter

Interface
REQ-001 Parameter NREQ, default 5, number of requesters (index 0..3 = per-port forwarders, 4 = control-frame issuer).
REQ-002 Parameter NPORT, default 4, number of PHY-TX FIFOs; bit p of any mask = PHY_ID p.
REQ-003 Parameter HOLD_MAX, default 16'd2048, watchdog limit in cycles; 0 disables the watchdog.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 mutex_req  in  NREQ*NPORT  requester r mask at bits [r*NPORT +: NPORT]; 0 = no request.
REQ-007 mutex_val  out  NREQ*NPORT  granted mask per requester, same packing.
REQ-008 port_busy  out  NPORT  bit p = 1 while FIFO p is owned.
REQ-009 timeout_pulse  out  NREQ  one-cycle pulse when requester r is force-released.
REQ-010 proto_err  out  1  sticky; set on illegal request change; cleared only by rst.

Function
REQ-011 Per port, an owner register (valid + requester index); port_busy = owner-valid bits.
REQ-012 Grants are all-or-nothing: mutex_val[r] = 0 or mutex_val[r] = mutex_req[r]; partial masks never appear.
REQ-013 Requester r is waiting when mutex_req[r] != 0, mutex_val[r] == 0, and not locked out (REQ-021).
REQ-014 At most one grant per cycle; arbitration uses registered owner state only.
REQ-015 Round-robin pointer rr_ptr; head = first waiting requester scanning rr_ptr, rr_ptr+1, ... mod NREQ.
REQ-016 Reserved mask = head's mask when the head cannot be granted (any bit owned); otherwise 0.
REQ-017 Winner = first waiting requester in scan order whose mask shares no bit with owned ports or the reserved mask; the head qualifies if none of its bits is owned.
REQ-018 On grant at edge N: owners of the mask's ports set to winner; mutex_val[winner] = mask from cycle N+1. Minimum request-to-grant latency is 1 cycle.
REQ-019 rr_ptr becomes (winner+1) mod NREQ only when winner == head; otherwise unchanged, so a blocked multi-port head is never starved.
REQ-020 Release: while holding, mutex_req[r] == 0 at edge N clears mutex_val[r] and frees its ports at that edge. Freed ports are grantable at edge N+1 earliest (1-cycle handoff gap).
REQ-021 Changing mutex_req[r] to a different nonzero mask while holding: ignored, grant kept, proto_err set. A new mask takes effect only after release through 0.
REQ-022 Watchdog: per-requester hold counter, cleared on grant, incremented each held cycle, saturating.
REQ-023 When a count reaches HOLD_MAX, that edge: mutex_val[r] cleared, ports freed, timeout_pulse[r] = 1 for one cycle. Requester r is then locked out until mutex_req[r] == 0 for at least one cycle.
REQ-024 Release by one requester and grant to another in the same cycle are legal when their masks are disjoint.
REQ-025 NREQ or NPORT beyond the request mask width is not required; only the parameter values above are verified.

Reset
REQ-026 Effects of rst = 1 at a rising edge:
- mutex_val = 0, port_busy = 0, timeout_pulse = 0, proto_err = 0
- all owners invalid, rr_ptr = 0, hold counters = 0, lockouts cleared
REQ-027 rst asserted mid-hold releases every grant immediately. Requests still asserted after rst deasserts are arbitrated normally from rr_ptr = 0.

Verification
REQ-028 Single grant: req[4] = 4'b0101 at cycle 0 -> mutex_val[4] = 4'b0101 and port_busy = 4'b0101 at cycle 1. req[4] = 0 at cycle 5 -> both 0 at cycle 6.
REQ-029 Contention: req[0] = req[1] = 4'b0001 simultaneously after reset -> requester 0 granted. Drop req[0] -> requester 1 granted exactly 2 cycles after drop edge.
REQ-030 Starvation guard:
- req[1] = 4'b0010 holds; req[4] = 4'b1111 waits as head; req[2] = 4'b0100 arrives.
- Requester 2 is not granted while the head is blocked.
- req[1] drops -> requester 4 gets 4'b1111.
REQ-031 Disjoint concurrency: req[0] = 4'b0001, req[3] = 4'b1000 -> grants on consecutive cycles; both held together; port_busy = 4'b1001.
REQ-032 Watchdog with HOLD_MAX = 8: grant held 8 cycles -> mutex_val cleared, timeout_pulse = 1 for one cycle. Re-grant only after req goes 0 then nonzero.
REQ-033 Protocol and reset:
- Holder changes 4'b0001 -> 4'b0011: grant stays 4'b0001, proto_err = 1.
- rst mid-hold -> all outputs 0 on the next cycle.
